// File: rtl/sprite_anim_draw.sv
`default_nettype none
// ============================================================================
// Module  : sprite_anim_draw
// Brief   : Multi-pose sprite drawer with mirroring, hit flash and key tint.
//           Define SPRITE_DEATH_BLINK_EN for the blinking death sequence.
// Revision: 1.0 - first release, replaces the fixed two-pose bird drawer
// ============================================================================
module sprite_anim_draw #(
    parameter int         OBJ_W_BITS   = 5,
    parameter int         OBJ_H_BITS   = 5,
    parameter int         NUM_FRAMES   = 4,
    parameter int         FRAME_TICKS  = 8,
    parameter int         FLASH_TICKS  = 16,
    parameter int         FLASH_PERIOD = 4,
    parameter logic [7:0] TRANSPARENT  = 8'hFF,
    parameter logic [7:0] FLASH_COLOR  = 8'hE0,
    parameter logic [7:0] KEY_COLOR    = 8'h33,
    localparam int        FRAME_BITS   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int        ADDR_BITS    = FRAME_BITS + OBJ_H_BITS + OBJ_W_BITS
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic [10:0]           offsetX,
    input  logic [10:0]           offsetY,
    input  logic                  InsideRectangle,
    input  logic                  hit,
    input  logic                  alive,
    input  logic                  mirror,
    input  logic [7:0]            tint,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [7:0]            rom_data,
    output logic                  drawingRequest,
    output logic [7:0]            RGBout,
    output logic [FRAME_BITS-1:0] frame_idx,
`ifdef SPRITE_DEATH_BLINK_EN
    output logic                  dying,
`endif
    output logic                  flashing
);

    localparam int TICK_BITS = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int REM_BITS  = $clog2(FLASH_TICKS + 1);
    localparam int PH_BITS   = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

`ifdef SPRITE_DEATH_BLINK_EN
    typedef enum logic [2:0] {ST_IDLE, ST_ON, ST_OFF, ST_DYING, ST_DEAD} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;
`endif

    state_t                r_state, w_state_nx;
    logic [REM_BITS-1:0]   r_remaining, w_rem_nx;
    logic [PH_BITS-1:0]    r_phase, w_phase_nx;
    logic [TICK_BITS-1:0]  r_anim_tick;
    logic                  r_inside_d;
    logic                  r_alive_d;
    logic                  w_period_end;
    logic                  w_last_tick;
    logic                  w_visible;
    logic [7:0]            w_colour;
    logic [OBJ_W_BITS-1:0] w_x;
    logic                  w_unused_ok;

    // W-1-x equals bitwise inversion because W is a power of two
    assign w_x         = mirror ? ~offsetX[OBJ_W_BITS-1:0] : offsetX[OBJ_W_BITS-1:0];
    assign rom_addr    = {frame_idx, offsetY[OBJ_H_BITS-1:0], w_x};
    assign w_unused_ok = &{1'b0, offsetX[10:OBJ_W_BITS], offsetY[10:OBJ_H_BITS]};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_anim_tick <= '0;
            frame_idx   <= '0;
        end else if (startOfFrame && alive) begin
            if (r_anim_tick == TICK_BITS'(FRAME_TICKS - 1)) begin
                r_anim_tick <= '0;
                if (frame_idx == FRAME_BITS'(NUM_FRAMES - 1))
                    frame_idx <= '0;
                else
                    frame_idx <= frame_idx + 1'b1;
            end else begin
                r_anim_tick <= r_anim_tick + 1'b1;
            end
        end
    end

`ifdef SPRITE_DEATH_BLINK_EN
    logic r_blink_odd, w_blink_nx;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_phase     <= '0;
`ifdef SPRITE_DEATH_BLINK_EN
            r_blink_odd <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_remaining <= w_rem_nx;
            r_phase     <= w_phase_nx;
`ifdef SPRITE_DEATH_BLINK_EN
            r_blink_odd <= w_blink_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_rem_nx     = r_remaining;
        w_phase_nx   = r_phase;
        w_period_end = (r_phase == PH_BITS'(FLASH_PERIOD - 1));
        w_last_tick  = (r_remaining == REM_BITS'(1));
`ifdef SPRITE_DEATH_BLINK_EN
        w_blink_nx   = r_blink_odd;
`endif
        if (!alive) begin
`ifdef SPRITE_DEATH_BLINK_EN
            if (r_state == ST_DYING) begin
                if (startOfFrame) begin
                    w_rem_nx   = r_remaining - 1'b1;
                    w_phase_nx = w_period_end ? '0 : r_phase + 1'b1;
                    if (w_period_end)
                        w_blink_nx = ~r_blink_odd;
                    if (w_last_tick)
                        w_state_nx = ST_DEAD;
                end
            end else if (r_state != ST_DEAD) begin
                // r_alive_d high means alive has just fallen
                w_state_nx = r_alive_d ? ST_DYING : ST_IDLE;
                w_rem_nx   = REM_BITS'(FLASH_TICKS);
                w_phase_nx = '0;
                w_blink_nx = 1'b0;
            end
`else
            w_state_nx = ST_IDLE;
`endif
        end else if (hit) begin
            w_state_nx = ST_ON;
            w_rem_nx   = REM_BITS'(FLASH_TICKS);
            w_phase_nx = '0;
        end else if ((r_state == ST_ON || r_state == ST_OFF) && startOfFrame) begin
            w_rem_nx   = r_remaining - 1'b1;
            w_phase_nx = w_period_end ? '0 : r_phase + 1'b1;
            if (w_last_tick)
                w_state_nx = ST_IDLE;
            else if (w_period_end)
                w_state_nx = (r_state == ST_ON) ? ST_OFF : ST_ON;
        end
`ifdef SPRITE_DEATH_BLINK_EN
        else if (r_state == ST_DYING || r_state == ST_DEAD) begin
            w_state_nx = ST_IDLE;
        end
`endif
    end

    assign flashing = (r_state == ST_ON) || (r_state == ST_OFF);
`ifdef SPRITE_DEATH_BLINK_EN
    assign dying     = (r_state == ST_DYING);
    assign w_visible = r_alive_d || ((r_state == ST_DYING) && !r_blink_odd);
`else
    assign w_visible = r_alive_d;
`endif

    always_comb begin
        w_colour = rom_data;
        if (!r_inside_d || rom_data == TRANSPARENT)
            w_colour = TRANSPARENT;
        else if (r_state == ST_ON)
            w_colour = FLASH_COLOR;
        else if (rom_data == KEY_COLOR)
            w_colour = tint;
    end

    // Pipeline: stage 1 aligns inside/alive with ROM data, stage 2 registers colour
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_inside_d     <= 1'b0;
            r_alive_d      <= 1'b0;
            RGBout         <= TRANSPARENT;
            drawingRequest <= 1'b0;
        end else begin
            r_inside_d     <= InsideRectangle;
            r_alive_d      <= alive;
            RGBout         <= w_colour;
            drawingRequest <= (w_colour != TRANSPARENT) && w_visible;
        end
    end

endmodule
`default_nettype wire
